// File: rtl/noise_prob_loader.sv
// noise_prob_loader: streams a CDF table from RAM into random_noise's probability write port, then releases the noise chain
// Ports: clk/rstn clock and async active-low reset; start loads the table, clear drops run_en from DONE;
//        rd_en/rd_addr/rd_data table RAM read port; probability_in/probability_idx write port (idx all-ones = no write);
//        busy high while loading, done one-cycle completion pulse, run_en level enable after a completed load.
module noise_prob_loader #(
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64,
    parameter int IDX_WIDTH  = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  clear,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] probability_in,
    output logic [IDX_WIDTH-1:0]  probability_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  run_en
);
    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, SETTLE, DONE} state_t;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
    state_t state, state_nxt;
    logic vld [RD_LATENCY];
    logic [ADDR_WIDTH-1:0] adr [RD_LATENCY];
    logic pending;
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < RD_LATENCY; i++) pending = pending | vld[i];
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end
    // DRAIN ends once the last read has left the pipeline, i.e. the cycle its write is on the port
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? LOAD : IDLE;
            LOAD:    state_nxt = (rd_addr == LAST) ? DRAIN : LOAD;
            DRAIN:   state_nxt = pending ? DRAIN : SETTLE;
            SETTLE:  state_nxt = DONE;
            DONE:    state_nxt = clear ? IDLE : start ? LOAD : DONE;
            default: state_nxt = IDLE;
        endcase
    end
    // Valid and address travel with each read so the write lines up with rd_data for any latency
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_en           <= 1'b0;
            rd_addr         <= '0;
            probability_in  <= '0;
            probability_idx <= '1;
            busy            <= 1'b0;
            done            <= 1'b0;
            run_en          <= 1'b0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                vld[i] <= 1'b0;
                adr[i] <= '0;
            end
        end else begin
            rd_en           <= state_nxt == LOAD;
            rd_addr         <= state_nxt != LOAD ? rd_addr : state == LOAD ? rd_addr + 1'b1 : '0;
            vld[0]          <= rd_en;
            adr[0]          <= rd_addr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld[i] <= vld[i-1];
                adr[i] <= adr[i-1];
            end
            probability_idx <= vld[RD_LATENCY-1] ? IDX_WIDTH'(adr[RD_LATENCY-1]) : '1;
            probability_in  <= vld[RD_LATENCY-1] ? rd_data : probability_in;
            busy            <= state_nxt inside {LOAD, DRAIN, SETTLE};
            done            <= state_nxt == DONE && state != DONE;
            run_en          <= state_nxt == DONE;
        end
    end
endmodule

// File: tb/tb_noise_prob_loader.sv
// tb_noise_prob_loader: random start/clear/reset stimulus on two loaders (read latency 1 and 3) with a write/done scoreboard
module tb_noise_prob_loader;
    localparam int DEPTH = 64;
    typedef struct {int cyc; int idx;} wr_t;
    logic clk = 1'b0, rstn = 1'b1, start = 1'b0, clear = 1'b0;
    logic [1:0] rd_en, busy, done, run_en;
    logic [1:0][5:0] rd_addr;
    logic [1:0][63:0] rd_data, pin;
    logic [1:0][31:0] pidx;
    int cyc = 0, checks = 0, failures = 0;
    int t0 [2] = '{-1, -1};
    wr_t wq [2][$];
    int dq [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int g);
        return g == 0 ? 1 : 3;
    endfunction

    function automatic logic [63:0] mem_val(input int k);
        return 64'h1000_0000_0000_0000 + 64'(k);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int L = (g == 0) ? 1 : 3;
        logic [63:0] pipe [L];
        noise_prob_loader #(.RD_LATENCY(L)) dut (
            .clk(clk), .rstn(rstn), .start(start), .clear(clear),
            .rd_en(rd_en[g]), .rd_addr(rd_addr[g]), .rd_data(rd_data[g]),
            .probability_in(pin[g]), .probability_idx(pidx[g]),
            .busy(busy[g]), .done(done[g]), .run_en(run_en[g])
        );
        always @(posedge clk) begin
            pipe[0] <= mem_val(int'(rd_addr[g]));
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign rd_data[g] = pipe[L-1];
    end

    task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s lat=%0d cyc=%0d got=%h expected=%h", nm, lat(g), cyc, act, exp);
        end
    endtask

    // Reference model: load timing is a pure function of the accepted start cycle t0
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            int l, s;
            logic eb, er, ed;
            l = lat(g);
            s = t0[g];
            eb = s >= 0 && cyc >= s + 1 && cyc <= s + DEPTH + 2 + l;
            er = s >= 0 && cyc >= s + DEPTH + 3 + l;
            ed = s >= 0 && cyc >= s + 1 && cyc <= s + DEPTH;
            if (!rstn) begin
                chk("rst_busy", g, busy[g], 0);
                chk("rst_run_en", g, run_en[g], 0);
                chk("rst_rd_en", g, rd_en[g], 0);
                chk("rst_idx", g, pidx[g], 32'hFFFF_FFFF);
                t0[g] = -1;
                wq[g].delete();
                dq[g].delete();
            end else begin
                chk("busy", g, busy[g], eb);
                chk("run_en", g, run_en[g], er);
                chk("rd_en", g, rd_en[g], ed);
                if (ed) chk("rd_addr", g, rd_addr[g], cyc - s - 1);
                if (start && (s < 0 || (er && !clear))) begin
                    t0[g] = cyc;
                    for (int k = 0; k < DEPTH; k++) wq[g].push_back('{cyc + 2 + k + l, k});
                    dq[g].push_back(cyc + DEPTH + 3 + l);
                end else if (er && clear) begin
                    t0[g] = -1;
                end
            end
        end
    end

    // Monitor: every write or done the DUT presents must match the head of its queue
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            wr_t e;
            if (rstn) begin
                if (pidx[g] !== 32'hFFFF_FFFF) begin
                    if (wq[g].size() == 0) chk("unexpected_write", g, pidx[g], 32'hFFFF_FFFF);
                    else begin
                        e = wq[g].pop_front();
                        chk("wr_idx", g, pidx[g], e.idx);
                        chk("wr_data", g, pin[g], mem_val(e.idx));
                        chk("wr_cycle", g, cyc, e.cyc);
                    end
                end else if (wq[g].size() != 0 && wq[g][0].cyc <= cyc) begin
                    chk("missing_write", g, pidx[g], wq[g][0].idx);
                    void'(wq[g].pop_front());
                end
                if (done[g]) begin
                    if (dq[g].size() == 0) chk("unexpected_done", g, done[g], 0);
                    else chk("done_cycle", g, cyc, dq[g].pop_front());
                end else if (dq[g].size() != 0 && dq[g][0] <= cyc) begin
                    chk("missing_done", g, done[g], 1);
                    void'(dq[g].pop_front());
                end
            end
        end
    end

    task automatic pulse(input logic s, input logic c);
        @(posedge clk); #1;
        start = s;
        clear = c;
        @(posedge clk); #1;
        start = 1'b0;
        clear = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #1 rstn = 1'b0;
        idle(3);
        #1 rstn = 1'b1;
        pulse(1, 0); idle(80);
        pulse(1, 0); idle(19); pulse(1, 0); idle(80);
        pulse(1, 0); idle(28);
        #1 rstn = 1'b0;
        idle(2);
        #1 rstn = 1'b1;
        idle(10);
        pulse(1, 0); idle(80);
        pulse(1, 1); idle(10);
        pulse(0, 1); idle(5);
        pulse(1, 1); idle(80);
        repeat (10) begin
            int r;
            r = int'($urandom_range(0, 4));
            if (r == 0) pulse(1, 0);
            else if (r == 1) pulse(1, 1);
            else if (r == 2) pulse(0, 1);
            else if (r == 3) begin
                pulse(1, 0);
                idle(int'($urandom_range(1, 70)));
                pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                pulse(1, 0);
                idle(int'($urandom_range(1, 70)));
                #1 rstn = 1'b0;
                idle(1);
                #1 rstn = 1'b1;
            end
            idle(int'($urandom_range(0, 90)));
        end
        idle(100);
        for (int g = 0; g < 2; g++) begin
            chk("leftover_writes", g, wq[g].size(), 0);
            chk("leftover_done", g, dq[g].size(), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
